// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: walks IDLE->ADDR->REQ->HOLD, pulses the PC and hands fetched words to the datapath.
// Define FETCH_TIMEOUT_EN to bound the memory wait at MAX_WAIT cycles with a sticky fetch_err.
module pc_fetch_ctrl #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              flush_req,
   input  logic              rewind_req,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic              pc_inc,
   output logic              pc_dec,
   output logic              pc_flush,
   output logic              pc_out_en,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_data,
   input  logic              instr_ack,
   output logic              busy,
   output logic              fetch_err
);

   typedef enum logic [1:0] {IDLE, ADDR, REQ, HOLD} state_t;

   state_t     state;
   logic [1:0] dec_left;
   logic       resume_run;

   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("MAX_WAIT must be at least 1");
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   logic [WAIT_W-1:0] wait_cnt;
`else
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         dec_left    <= 2'd0;
         resume_run  <= 1'b0;
         pc_inc      <= 1'b0;
         pc_dec      <= 1'b0;
         pc_flush    <= 1'b0;
         pc_out_en   <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         instr_valid <= 1'b0;
         instr_data  <= '0;
         busy        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt    <= '0;
         fetch_err   <= 1'b0;
`endif
      end else begin
         pc_inc   <= 1'b0;
         pc_dec   <= 1'b0;
         pc_flush <= 1'b0;
         if (flush_req) begin
            // Flush overrides everything, including a same-cycle mem_ready and queued dec pulses.
            state       <= IDLE;
            busy        <= 1'b0;
            pc_flush    <= 1'b1;
            pc_out_en   <= 1'b0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            dec_left    <= 2'd0;
            resume_run  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= '0;
            fetch_err   <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (run) begin
                     state     <= ADDR;
                     busy      <= 1'b1;
                     pc_out_en <= 1'b1;
                  end
               end
               ADDR: begin
                  pc_out_en <= 1'b0;
                  mem_addr  <= pc_addr;
                  mem_req   <= 1'b1;
                  state     <= REQ;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt  <= '0;
`endif
               end
               REQ: begin
                  if (mem_ready) begin
                     instr_data  <= mem_rdata;
                     instr_valid <= 1'b1;
                     mem_req     <= 1'b0;
                     pc_inc      <= 1'b1;
                     state       <= HOLD;
                  end
`ifdef FETCH_TIMEOUT_EN
                  else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                     fetch_err <= 1'b1;
                     mem_req   <= 1'b0;
                     pc_flush  <= 1'b1;
                     state     <= IDLE;
                     busy      <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
`endif
               end
               HOLD: begin
                  // A rewind issues two dec pulses back to back; ADDR waits until the PC has settled.
                  if (dec_left == 2'd2) begin
                     pc_dec   <= 1'b1;
                     dec_left <= 2'd1;
                  end else if (dec_left == 2'd1) begin
                     dec_left  <= 2'd0;
                     state     <= resume_run ? ADDR : IDLE;
                     pc_out_en <= resume_run;
                     busy      <= resume_run;
                  end else if (instr_ack) begin
                     instr_valid <= 1'b0;
                     if (rewind_req) begin
                        pc_dec     <= 1'b1;
                        dec_left   <= 2'd2;
                        resume_run <= run;
                     end else begin
                        state     <= run ? ADDR : IDLE;
                        pc_out_en <= run;
                        busy      <= run;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: a simple PC and memory around the DUT, checked against an address/pulse-count model.
module tb_pc_fetch_ctrl;
   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 16;
   localparam int MAX_WAIT = 15;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              run = 1'b0;
   logic              flush_req = 1'b0;
   logic              rewind_req = 1'b0;
   logic [ADDR_W-1:0] pc_addr;
   logic              pc_inc, pc_dec, pc_flush, pc_out_en, mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_data;
   logic              instr_ack = 1'b0;
   logic              busy, fetch_err;

   pc_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset(reset), .run(run), .flush_req(flush_req), .rewind_req(rewind_req),
      .pc_addr(pc_addr), .pc_inc(pc_inc), .pc_dec(pc_dec), .pc_flush(pc_flush),
      .pc_out_en(pc_out_en), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_data(instr_data),
      .instr_ack(instr_ack), .busy(busy), .fetch_err(fetch_err)
   );

   always #5 clock = ~clock;

   // Program counter driven by the pulses; bus shows garbage whenever the driver is disabled.
   logic [ADDR_W-1:0] pc_q = '0;
   logic              pc_load = 1'b0;
   logic [ADDR_W-1:0] pc_load_val = '0;
   always @(posedge clock) begin
      if (pc_load)       pc_q <= pc_load_val;
      else if (pc_flush) pc_q <= '0;
      else if (pc_inc)   pc_q <= pc_q + 12'd1;
      else if (pc_dec)   pc_q <= pc_q - 12'd1;
   end
   assign pc_addr = pc_out_en ? pc_q : ~pc_q;

   int inc_n = 0, dec_n = 0, flush_n = 0, excl_n = 0;
   always @(negedge clock) begin
      if (reset) begin
         if (pc_inc)   inc_n++;
         if (pc_dec)   dec_n++;
         if (pc_flush) flush_n++;
         if ((pc_inc && pc_dec) || ((pc_inc || pc_dec) && pc_flush)) excl_n++;
      end
   end

   int checks = 0, errors = 0;
   logic [ADDR_W-1:0] exp_addr = '0;
   int exp_inc = 0, exp_dec = 0, exp_flush = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_inc"}, pc_inc, 0);
      chk({tag, "_dec"}, pc_dec, 0);
      chk({tag, "_flush"}, pc_flush, 0);
      chk({tag, "_oe"}, pc_out_en, 0);
      chk({tag, "_req"}, mem_req, 0);
      chk({tag, "_maddr"}, mem_addr, 0);
      chk({tag, "_ivld"}, instr_valid, 0);
      chk({tag, "_idata"}, instr_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, fetch_err, 0);
   endtask

   task automatic wait_req();
      int n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("req_seen", mem_req, 1);
   endtask

   // One full fetch at exp_addr; the model then advances exp_addr by +1 or, on rewind, -1.
   task automatic do_fetch(input int lat, input logic [DATA_W-1:0] d, input int ack_dly,
                           input logic rw, input logic keep);
      logic ok;
      wait_req();
      chk("mem_addr", mem_addr, exp_addr);
      if (!keep) run = 1'b0;
      ok = 1'b1;
      repeat (lat) begin
         @(negedge clock);
         if (mem_req !== 1'b1 || mem_addr !== exp_addr || instr_valid !== 1'b0) ok = 1'b0;
      end
      chk("req_hold", ok, 1);
      mem_ready = 1'b1;
      mem_rdata = d;
      @(negedge clock);
      mem_ready = 1'b0;
      mem_rdata = 16'($urandom);
      chk("ivld_set", instr_valid, 1);
      chk("idata", instr_data, d);
      chk("req_drop", mem_req, 0);
      chk("inc_pulse", pc_inc, 1);
      ok = 1'b1;
      repeat (ack_dly) begin
         @(negedge clock);
         if (instr_valid !== 1'b1 || instr_data !== d) ok = 1'b0;
      end
      chk("ivld_hold", ok, 1);
      instr_ack  = 1'b1;
      rewind_req = rw;
      run        = keep;
      @(negedge clock);
      instr_ack  = 1'b0;
      rewind_req = 1'b0;
      chk("ivld_drop", instr_valid, 0);
      if (rw) begin
         chk("dec_1", pc_dec, 1);
         @(negedge clock);
         chk("dec_2", pc_dec, 1);
         @(negedge clock);
         chk("dec_end", pc_dec, 0);
      end
      exp_inc++;
      if (rw) begin
         exp_dec += 2;
         exp_addr = exp_addr - 12'd1;
      end else begin
         exp_addr = exp_addr + 12'd1;
      end
   endtask

   initial begin
      int snap_inc, snap_dec, snap_flush;
      // Reset state with the PC preset to 0x010
      pc_load = 1'b1;
      pc_load_val = 12'h010;
      repeat (2) @(negedge clock);
      pc_load = 1'b0;
      chk_all_zero("rst");
      reset = 1'b1;
      exp_addr = 12'h010;
      mem_ready = 1'b1;
      mem_rdata = 16'h1234;
      @(negedge clock);
      mem_ready = 1'b0;
      chk("ready_in_idle", instr_valid, 0);
      chk("idle_busy", busy, 0);

      // run to first mem_req is two cycles, first word 0xA5C3
      run = 1'b1;
      @(negedge clock);
      chk("addr_oe", pc_out_en, 1);
      chk("addr_busy", busy, 1);
      chk("addr_noreq", mem_req, 0);
      @(negedge clock);
      chk("req_oe_off", pc_out_en, 0);
      chk("req_lat", mem_req, 1);
      do_fetch(3, 16'hA5C3, 1, 1'b0, 1'b1);
      do_fetch(int'($urandom_range(0, 4)), 16'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b1);
      do_fetch(int'($urandom_range(0, 4)), 16'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0);
      #1;
      chk("inc_cnt3", inc_n, exp_inc);
      chk("dec_cnt0", dec_n, 0);
      chk("back_idle", busy, 0);

      // Rewind at 0x021 must refetch 0x020
      @(negedge clock);
      pc_load = 1'b1;
      pc_load_val = 12'h021;
      @(negedge clock);
      pc_load = 1'b0;
      exp_addr = 12'h021;
      run = 1'b1;
      do_fetch(1, 16'h0F0F, 0, 1'b1, 1'b1);
      chk("rewind_model", exp_addr, 12'h020);
      do_fetch(2, 16'h3C3C, 2, 1'b0, 1'b1);

      // Randomized fetch stream
      for (int i = 0; i < 12; i++) begin
         do_fetch(int'($urandom_range(0, 5)), 16'($urandom), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), 1'b1);
      end

      // Flush during REQ coinciding with mem_ready
      wait_req();
      flush_req = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 16'hDEAD;
      run = 1'b0;
      @(negedge clock);
      flush_req = 1'b0;
      mem_ready = 1'b0;
      chk("fl_pulse", pc_flush, 1);
      chk("fl_ivld", instr_valid, 0);
      chk("fl_req", mem_req, 0);
      chk("fl_busy", busy, 0);
      chk("fl_inc", pc_inc, 0);
      exp_flush++;
      exp_addr = '0;
      @(negedge clock);
      chk("fl_once", pc_flush, 0);
      chk("fl_idle", busy, 0);
      run = 1'b1;
      do_fetch(2, 16'h5A5A, 1, 1'b0, 1'b0);
      chk("post_fl_idle", busy, 0);

      // Memory never answers
      run = 1'b1;
      wait_req();
      run = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      begin
         int n = 0;
         while (mem_req === 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
         end
         chk("to_cycles", n, MAX_WAIT);
         chk("to_err", fetch_err, 1);
         chk("to_flush", pc_flush, 1);
         chk("to_busy", busy, 0);
         exp_flush++;
         @(negedge clock);
         chk("to_sticky", fetch_err, 1);
         flush_req = 1'b1;
         @(negedge clock);
         flush_req = 1'b0;
         chk("to_clear", fetch_err, 0);
         exp_flush++;
         exp_addr = '0;
      end
`else
      run = 1'b1;
      do_fetch(40, 16'hBEEF, 0, 1'b0, 1'b0);
      chk("no_to_err", fetch_err, 0);
`endif
      @(negedge clock);
      #1;
      chk("inc_total", inc_n, exp_inc);
      chk("dec_total", dec_n, exp_dec);
      chk("flush_total", flush_n, exp_flush);
      chk("exclusive", excl_n, 0);

      // Asynchronous reset mid-HOLD
      run = 1'b1;
      wait_req();
      mem_ready = 1'b1;
      mem_rdata = 16'h7777;
      @(negedge clock);
      mem_ready = 1'b0;
      chk("hold_vld", instr_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("arst");
      snap_inc = inc_n;
      snap_dec = dec_n;
      snap_flush = flush_n;
      run = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      #1;
      chk("arst_inc", inc_n, snap_inc);
      chk("arst_dec", dec_n, snap_dec);
      chk("arst_flush", flush_n, snap_flush);
      chk("arst_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end
endmodule
